// File: rtl/md5_search_ctrl_pkg.sv
// ============================================================================
// Module : md5_search_ctrl_pkg
// Brief  : Shared types, character bounds and candidate odometer helpers.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package md5_search_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RUN       = 3'd1,
        ST_DRAIN     = 3'd2,
        ST_FOUND     = 3'd3,
        ST_EXHAUSTED = 3'd4
    } state_t;

    localparam logic [7:0]  CHAR_FIRST = 8'h61;
    localparam logic [7:0]  CHAR_LAST  = 8'h7A;

    localparam logic [31:0] MD5_INIT_A = 32'h67452301;
    localparam logic [31:0] MD5_INIT_B = 32'hEFCDAB89;
    localparam logic [31:0] MD5_INIT_C = 32'h98BADCFE;
    localparam logic [31:0] MD5_INIT_D = 32'h10325476;

    typedef struct packed {
        logic [3:0]  count;
        logic [63:0] msg;
    } cand_t;

    // Byte 0 is the last character; a carry out of the top used byte grows
    // the candidate by one character and restarts it at all 'a'.
    function automatic cand_t odometer_next(input cand_t cur);
        cand_t nxt;
        logic  carry;
        nxt   = cur;
        carry = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (carry && (4'(i) < cur.count)) begin
                if (cur.msg[8*i +: 8] == CHAR_LAST) begin
                    nxt.msg[8*i +: 8] = CHAR_FIRST;
                end else begin
                    nxt.msg[8*i +: 8] = cur.msg[8*i +: 8] + 8'd1;
                    carry             = 1'b0;
                end
            end
        end
        if (carry) begin
            nxt.count = cur.count + 4'd1;
            nxt.msg   = '0;
            for (int i = 0; i < 8; i++) begin
                if (4'(i) < nxt.count) begin
                    nxt.msg[8*i +: 8] = CHAR_FIRST;
                end
            end
        end
        return nxt;
    endfunction

    function automatic logic is_final(input cand_t c, input logic [3:0] max_cnt);
        logic all_z;
        all_z = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if ((4'(i) < c.count) && (c.msg[8*i +: 8] != CHAR_LAST)) begin
                all_z = 1'b0;
            end
        end
        return all_z && (c.count == max_cnt);
    endfunction

endpackage

`default_nettype wire

// File: rtl/md5_search_ctrl_if.sv
// ============================================================================
// Module : md5_search_ctrl_if
// Brief  : Host/core-side bundle of the brute-force search controller.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface md5_search_ctrl_if;
    logic         start;
    logic [127:0] target;
    logic [63:0]  message;
    logic [63:0]  length;
    logic [127:0] hash;
    logic [511:0] message_out;
    logic         busy;
    logic         found;
    logic         exhausted;
    logic [63:0]  found_message;
    logic [3:0]   found_len;

    modport master (
        output start, target, hash, message_out,
        input  message, length, busy, found, exhausted, found_message, found_len
    );

    modport slave (
        input  start, target, hash, message_out,
        output message, length, busy, found, exhausted, found_message, found_len
    );
endinterface

`default_nettype wire

// File: rtl/md5_tag_delay.sv
// ============================================================================
// Module : md5_tag_delay
// Brief  : Fixed-depth valid+data shift line with a valid-only flush.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md5_tag_delay #(
    parameter int DEPTH = 66,
    parameter int WIDTH = 69
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             flush,
    input  wire logic             in_valid,
    input  wire logic [WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data
);

    logic [DEPTH-1:0] valid_sr;
    logic [WIDTH-1:0] data_sr [DEPTH];

    // The entry arriving on a flush cycle is discarded as well.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_sr <= '0;
        end else begin
            valid_sr[0] <= in_valid & ~flush;
            for (int i = 1; i < DEPTH; i++) begin
                valid_sr[i] <= valid_sr[i-1] & ~flush;
            end
        end
    end

    always_ff @(posedge clk) begin
        data_sr[0] <= in_data;
        for (int i = 1; i < DEPTH; i++) begin
            data_sr[i] <= data_sr[i-1];
        end
    end

    assign out_valid = valid_sr[DEPTH-1];
    assign out_data  = data_sr[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/md5_search_ctrl.sv
// ============================================================================
// Module : md5_search_ctrl
// Brief  : Feeds lowercase candidates to an MD5 core and watches for a target.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md5_search_ctrl
    import md5_search_ctrl_pkg::*;
#(
    parameter int PIPE_LATENCY = 66,
    parameter int MAX_LEN      = 8
) (
    input  wire logic         clk,
    input  wire logic         rst,
    md5_search_ctrl_if.slave  bus
);

    localparam int         TAG_W   = 1 + 4 + 64;
    localparam logic [3:0] MAX_CNT = 4'(MAX_LEN);

    state_t       state;
    state_t       state_n;
    logic [127:0] target_q;
    cand_t        cur;
    cand_t        cur_next;
    logic         issuing;
    logic         found_q;
    logic         exhausted_q;
    logic [63:0]  found_msg_q;
    logic [3:0]   found_len_q;

    logic             last_issue;
    logic             dl_valid;
    logic [TAG_W-1:0] dl_data;
    logic             dl_last;
    logic [3:0]       dl_count;
    logic [63:0]      dl_msg;
    logic             match;
    logic             accept;
    logic             hit;
    logic             finish_run;
    logic             exhaust;
    logic             debug_unused;

    assign cur_next   = odometer_next(cur);
    assign last_issue = issuing && is_final(cur, MAX_CNT);

    md5_tag_delay #(
        .DEPTH (PIPE_LATENCY),
        .WIDTH (TAG_W)
    ) u_tag_delay (
        .clk       (clk),
        .rst       (rst),
        .flush     (hit),
        .in_valid  (issuing),
        .in_data   ({last_issue, cur.count, cur.msg}),
        .out_valid (dl_valid),
        .out_data  (dl_data)
    );

    assign dl_last  = dl_data[TAG_W-1];
    assign dl_count = dl_data[67:64];
    assign dl_msg   = dl_data[63:0];
    assign match    = dl_valid && (bus.hash == target_q);

    always_comb begin
        state_n    = state;
        accept     = 1'b0;
        hit        = 1'b0;
        finish_run = 1'b0;
        exhaust    = 1'b0;
        case (state)
            ST_IDLE, ST_FOUND, ST_EXHAUSTED: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_n = ST_RUN;
                end
            end
            ST_RUN: begin
                // A match outranks running out of candidates on the same cycle.
                if (match) begin
                    hit     = 1'b1;
                    state_n = ST_FOUND;
                end else if (last_issue) begin
                    finish_run = 1'b1;
                    state_n    = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (match) begin
                    hit     = 1'b1;
                    state_n = ST_FOUND;
                end else if (dl_valid && dl_last) begin
                    exhaust = 1'b1;
                    state_n = ST_EXHAUSTED;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            target_q    <= '0;
            cur         <= '0;
            issuing     <= 1'b0;
            found_q     <= 1'b0;
            exhausted_q <= 1'b0;
            found_msg_q <= '0;
            found_len_q <= '0;
        end else if (accept) begin
            target_q    <= bus.target;
            cur         <= '{count: 4'd1, msg: 64'(CHAR_FIRST)};
            issuing     <= 1'b1;
            found_q     <= 1'b0;
            exhausted_q <= 1'b0;
        end else if (hit) begin
            found_q     <= 1'b1;
            found_msg_q <= dl_msg;
            found_len_q <= dl_count;
            cur         <= '0;
            issuing     <= 1'b0;
        end else if (finish_run) begin
            cur     <= '0;
            issuing <= 1'b0;
        end else if (state == ST_RUN) begin
            cur <= cur_next;
        end else if (exhaust) begin
            exhausted_q <= 1'b1;
        end
    end

    assign debug_unused      = ^bus.message_out;

    assign bus.message       = cur.msg;
    assign bus.length        = {57'd0, cur.count, 3'd0};
    assign bus.busy          = (state == ST_RUN) || (state == ST_DRAIN);
    assign bus.found         = found_q;
    assign bus.exhausted     = exhausted_q;
    assign bus.found_message = found_msg_q;
    assign bus.found_len     = found_len_q;

endmodule

`default_nettype wire

// File: doc/md5_search_ctrl.md
MD5_SEARCH_CTRL -- requirements
Module: md5_search_ctrl

Interface
REQ-001 SHALL have parameter PIPE_LATENCY, default 66, cycles from message/length driven to matching hash/message_out valid at core output.
REQ-002 SHALL have parameter MAX_LEN, default 8, maximum candidate length in characters (1..8).
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 start  in  1  one-cycle pulse; begin search (ignored while busy).
REQ-007 target  in  128  hash to find; sampled on accepted start.
REQ-008 message  out  64  candidate to core, registered.
REQ-009 length  out  64  candidate length in bits (8*chars) to core, registered.
REQ-010 hash  in  128  core output hash.
REQ-011 message_out  in  512  core padded-message output; unused except by debug.
REQ-012 busy  out  1  high in RUN and DRAIN.
REQ-013 found  out  1  sticky until next start; match captured.
REQ-014 exhausted  out  1  sticky until next start; space searched, no match.
REQ-015 found_message  out  64  candidate whose hash equalled target.
REQ-016 found_len  out  4  character count of found_message.

Function
REQ-017 States SHALL be IDLE, RUN, DRAIN, FOUND, EXHAUSTED; start accepted in IDLE, FOUND, EXHAUSTED -> RUN, clears found/exhausted, latches target.
REQ-018 Candidate chars SHALL be 'a'(0x61)..'z'(0x7A); a len-N candidate occupies message[8N-1:0], upper bits zero, first char in most significant used byte.
REQ-019 First candidate after start SHALL be "a" (message=0x61, length=8), driven the cycle after start; one new candidate per cycle in RUN.
REQ-020 Increment SHALL be odometer: byte 0 +1; 'z' wraps to 'a' with carry to next byte; carry out of byte N-1 -> length N+1, all N+1 bytes 'a'.
REQ-021 After issuing all-'z' of length MAX_LEN, SHALL enter DRAIN, drive message=0/length=0, issue nothing further.
REQ-022 A PIPE_LATENCY-deep delay line SHALL carry {valid, char count, candidate} alongside the core; hash compared only when delay-line output valid=1.
REQ-023 On valid hash==target (RUN or DRAIN) SHALL, next cycle: enter FOUND, found=1, latch found_message/found_len from delay line, stop issuing, flush delay line valids.
REQ-024 DRAIN SHALL enter EXHAUSTED when the last valid entry leaves the delay line without match; exhausted=1.
REQ-025 Only the first match SHALL be reported; later matches ignored.
REQ-026 Match on the same cycle the last candidate is issued SHALL give FOUND, not DRAIN.
REQ-027 busy SHALL be 0 in IDLE/FOUND/EXHAUSTED; found and exhausted never both 1.

Reset
REQ-028 rst SHALL force IDLE, clear delay line valids, all outputs 0 (message, length, busy, found, exhausted, found_message, found_len), target 0.
REQ-029 rst mid-RUN/DRAIN SHALL abort with no found/exhausted; next start restarts from "a".

Structure
REQ-030 Shared package SHALL hold state enum, CHAR_FIRST=0x61, CHAR_LAST=0x7A, MD5 initial words.
REQ-031 Delay line SHALL be sub-module md5_tag_delay (params DEPTH, WIDTH; in valid+data, out valid+data, flush).
REQ-032 Odometer SHALL be a function in the package; FSM and compare in md5_search_ctrl.

Verification (bench uses behavioural core stub: hash={64'h0,message} delayed PIPE_LATENCY)
REQ-033 target={64'h0,64'h61}, start -> found=1 at start+PIPE_LATENCY+2, found_message=0x61, found_len=1.
REQ-034 target={64'h0,64'h6162} ("ab"), MAX_LEN=2 -> candidates a..z, aa..az, ba, ...; found_message=0x6162, found_len=2.
REQ-035 MAX_LEN=1, target=128'h1 -> 26 candidates, last 0x7A, then DRAIN, exhausted=1 after PIPE_LATENCY more cycles, found=0.
REQ-036 Wrap: check 0x7A7A -> 0x616161, length 16 -> 24.
REQ-037 rst asserted mid-RUN at cycle 10 -> all outputs 0 same cycle; start again -> first candidate 0x61.
REQ-038 start pulsed while busy -> ignored, candidate sequence unchanged.
